// File: rtl/sprite_motion_sched.sv
// Frame-synchronous sprite motion scheduler and beam priority resolver.
// Sprites are updated one at a time in blanking; the lowest-index covering sprite is reported per pixel.
module sprite_motion_sched #(
   parameter int unsigned CORDW    = 10,
   parameter int unsigned N_SPR    = 4,
   parameter int unsigned IDW      = $clog2(N_SPR),
   parameter int unsigned H_RES    = 640,
   parameter int unsigned V_RES    = 480,
   parameter int unsigned SPR_SIZE = 32
) (
   input  logic             clk_pix,
   input  logic             rst_n,
   input  logic             frame_start,
   input  logic [CORDW-1:0] sx,
   input  logic [CORDW-1:0] sy,
   input  logic             de,
   input  logic             cfg_we,
   input  logic [IDW-1:0]   cfg_id,
   input  logic             cfg_en,
   input  logic [CORDW-1:0] cfg_x,
   input  logic [CORDW-1:0] cfg_y,
   input  logic [3:0]       cfg_dx,
   input  logic [3:0]       cfg_dy,
   output logic             busy,
   output logic             upd_done,
   output logic             cfg_drop,
   output logic             overrun,
   output logic             hit,
   output logic [IDW-1:0]   hit_id
);

   localparam logic signed [CORDW+1:0] X_MAX = (CORDW+2)'(H_RES - SPR_SIZE);
   localparam logic signed [CORDW+1:0] Y_MAX = (CORDW+2)'(V_RES - SPR_SIZE);
   localparam logic [CORDW:0]          SIZE_W = (CORDW+1)'(SPR_SIZE);
   localparam logic [IDW-1:0]          LAST   = IDW'(N_SPR - 1);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   state_t                 state;
   logic [IDW-1:0]         idx;

   logic                   spr_en [N_SPR];
   logic [CORDW-1:0]       spr_x  [N_SPR];
   logic [CORDW-1:0]       spr_y  [N_SPR];
   logic signed [3:0]      spr_dx [N_SPR];
   logic signed [3:0]      spr_dy [N_SPR];

   logic                   w_en;
   logic [CORDW-1:0]       w_x, w_y;
   logic signed [3:0]      w_dx, w_dy;

   logic [CORDW+3:0]       upd_xv, upd_yv;
   logic                   hit_c;
   logic [IDW-1:0]         hit_id_c;

   // Velocity reversal; -8 has no positive twin in 4 bits so it saturates to +7.
   function automatic logic signed [3:0] neg_vel(input logic signed [3:0] v);
      return (v == 4'sb1000) ? 4'sb0111 : -v;
   endfunction

   // Returns {velocity, position} after one frame of motion with edge bounce.
   function automatic logic [CORDW+3:0] bounce(input logic [CORDW-1:0]        p,
                                               input logic signed [3:0]       v,
                                               input logic signed [CORDW+1:0] lim);
      logic signed [CORDW+1:0] n;
      n = $signed({2'b00, p}) + (CORDW+2)'(v);
      if (n[CORDW+1])
         return {neg_vel(v), CORDW'(0)};
      else if (n > lim)
         return {neg_vel(v), lim[CORDW-1:0]};
      return {v, n[CORDW-1:0]};
   endfunction

   always_comb begin
      upd_xv = bounce(w_x, w_dx, X_MAX);
      upd_yv = bounce(w_y, w_dy, Y_MAX);
   end

   // Priority cover test: first enabled sprite under the beam wins.
   always_comb begin
      hit_c    = 1'b0;
      hit_id_c = '0;
      for (int i = 0; i < int'(N_SPR); i++) begin
         if (!hit_c && de && spr_en[i] &&
             sx >= spr_x[i] && {1'b0, sx} < {1'b0, spr_x[i]} + SIZE_W &&
             sy >= spr_y[i] && {1'b0, sy} < {1'b0, spr_y[i]} + SIZE_W) begin
            hit_c    = 1'b1;
            hit_id_c = IDW'(i);
         end
      end
   end

   always_ff @(posedge clk_pix) begin
      if (!rst_n) begin
         state    <= IDLE;
         idx      <= '0;
         busy     <= 1'b0;
         upd_done <= 1'b0;
         cfg_drop <= 1'b0;
         overrun  <= 1'b0;
         hit      <= 1'b0;
         hit_id   <= '0;
         w_en     <= 1'b0;
         w_x      <= '0;
         w_y      <= '0;
         w_dx     <= '0;
         w_dy     <= '0;
         for (int i = 0; i < int'(N_SPR); i++) begin
            spr_en[i] <= 1'b0;
            spr_x[i]  <= '0;
            spr_y[i]  <= '0;
            spr_dx[i] <= '0;
            spr_dy[i] <= '0;
         end
      end else begin
         upd_done <= 1'b0;
         cfg_drop <= cfg_we && busy;
         overrun  <= frame_start && busy;
         hit      <= hit_c;
         hit_id   <= hit_id_c;
         case (state)
            IDLE: begin
               if (cfg_we) begin
                  spr_en[cfg_id] <= cfg_en;
                  spr_x[cfg_id]  <= cfg_x;
                  spr_y[cfg_id]  <= cfg_y;
                  spr_dx[cfg_id] <= $signed(cfg_dx);
                  spr_dy[cfg_id] <= $signed(cfg_dy);
               end
               if (frame_start) begin
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= RD;
               end
            end
            RD: begin
               w_en  <= spr_en[idx];
               w_x   <= spr_x[idx];
               w_y   <= spr_y[idx];
               w_dx  <= spr_dx[idx];
               w_dy  <= spr_dy[idx];
               state <= WR;
            end
            WR: begin
               spr_x[idx]  <= w_en ? upd_xv[CORDW-1:0] : w_x;
               spr_dx[idx] <= w_en ? $signed(upd_xv[CORDW+3:CORDW]) : w_dx;
               spr_y[idx]  <= w_en ? upd_yv[CORDW-1:0] : w_y;
               spr_dy[idx] <= w_en ? $signed(upd_yv[CORDW+3:CORDW]) : w_dy;
               if (idx == LAST) begin
                  upd_done <= 1'b1;
                  state    <= DONE;
               end else begin
                  idx   <= idx + IDW'(1);
                  state <= RD;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/sprite_motion_sched.md
# sprite_motion_sched

Frame-synchronous motion scheduler and priority resolver for up to N_SPR square sprites in the 640x480 simple_480p pipeline. The block owns all sprite position and velocity state. During vertical blanking it walks the sprites one at a time through a single shared update datapath, applying velocity and edge bounce. During active video it compares the beam position against every sprite and reports the lowest-index covering sprite to the colour stage.

## Interface
Parameters:
- CORDW, 10, coordinate width
- N_SPR, 4, sprite count (2..8)
- IDW, $clog2(N_SPR), sprite index width
- H_RES, 640, active width in pixels
- V_RES, 480, active height in pixels
- SPR_SIZE, 32, sprite edge length in pixels

Ports (one clock; reset is synchronous and active-low):
- clk_pix  in  1  pixel clock; all logic on its rising edge
- rst_n  in  1  synchronous active-low reset
- frame_start  in  1  one-cycle pulse at start of vertical blanking (sy==V_RES, sx==0)
- sx, sy  in  CORDW each  current beam position
- de  in  1  data enable
- cfg_we  in  1  config write strobe
- cfg_id  in  IDW  sprite to configure
- cfg_en  in  1  sprite enable
- cfg_x, cfg_y  in  CORDW each  initial position
- cfg_dx, cfg_dy  in  4 each  signed velocity, pixels/frame
- busy  out  1  update sequence in progress
- upd_done  out  1  one-cycle pulse when all sprites are updated
- cfg_drop  out  1  one-cycle pulse: config write rejected
- overrun  out  1  one-cycle pulse: frame_start arrived while busy
- hit  out  1  registered: an enabled sprite covers (sx,sy) and de=1
- hit_id  out  IDW  registered index of the covering sprite

## Operation
- Per-sprite state: en, x, y, dx, dy. On reset every field is 0.
- Output reset values: busy, upd_done, cfg_drop, overrun, hit and hit_id are all 0.
- FSM states: IDLE, RD, WR, DONE.
  - IDLE: on frame_start, set idx=0 and go to RD.
  - RD: latch sprite[idx] into the working registers; go to WR.
  - WR: write the result back. If idx==N_SPR-1 go to DONE, else idx++ and go to RD.
  - DONE: upd_done=1, then go to IDLE.
- Disabled sprites still take their RD/WR slot but are written back unchanged, so the sequence length is fixed.
- Update arithmetic is done at CORDW+2 bits signed, with nx = x + sext(dx):
  - nx<0: x=0 and dx=-dx.
  - nx>H_RES-SPR_SIZE: x=H_RES-SPR_SIZE and dx=-dx.
  - otherwise x=nx.
  - y, dy follow the same rule with V_RES.
  - Negating -8 saturates to +7.
- Config writes:
  - In IDLE, cfg_we updates all five fields of sprite[cfg_id] at the clock edge.
  - When busy=1, cfg_we is ignored and cfg_drop pulses the next cycle.
  - If cfg_we and frame_start arrive together in IDLE, the write is applied first and the update uses the new values.
- Hit detection:
  - Sprite i covers the beam when en_i, x_i<=sx<x_i+SPR_SIZE and y_i<=sy<y_i+SPR_SIZE, with sums at CORDW+1 bits so there is no wrap.
  - The lowest covering index wins.
  - hit=0 and hit_id=0 when de=0 or no sprite covers the beam.
- frame_start while busy is ignored (the sequence is not restarted) and overrun pulses the next cycle.
- rst_n low in any state returns the FSM to IDLE and clears all state at that edge. A partial update is discarded, not completed.

## Timing
- frame_start is sampled high at edge t. RD is active in cycle t+1; sprite k has RD at cycle t+1+2k and WR at t+2+2k.
- DONE is active in cycle t+2N_SPR+1, with upd_done=1 in that cycle only.
- busy is 1 in cycles t+1 through t+2N_SPR+1 inclusive. It is decoded from registered state, so there is no combinational path from frame_start.
- The sequence fits within blanking (45 lines) for any legal N_SPR.
- hit/hit_id latency is 1 cycle from sx/sy/de. Downstream registers sx/sy/de by one stage to align.
- Positions written in WR are visible to hit logic on the next cycle.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with frame_start=1 -> all outputs 0 and busy never rises. After release, one frame_start -> busy is high for exactly 9 cycles (N_SPR=4) and upd_done pulses once at the last busy cycle.
- Motion: configure sprite 0 with en=1, x=100, y=50, dx=+4, dy=-3, then 1 frame_start -> x=104, y=47. Beam at (104,47) with de=1 -> hit=1, hit_id=0 one cycle later. Beam at (136,47) -> hit=0.
- Bounce: configure x=606, dx=+5 -> x=608, dx=-5. Configure y=2, dy=-8 -> y=0, dy=+7. Configure x=608, dx=0 -> unchanged.
- Priority: sprites 1 and 3 both enabled at (200,200); beam at (210,210) -> hit_id=1. Disable sprite 1 -> hit_id=3. de=0 -> hit=0.
- Contention: cfg_we 2 cycles after frame_start -> cfg_drop pulses and the target sprite is unchanged. A second frame_start mid-sequence -> overrun pulses and the sequence still ends at t+9.
- Reset mid-update: assert rst_n=0 during sprite 2's WR -> the next cycle has busy=0 and all positions 0. A following frame_start runs a normal 9-cycle sequence.
